// File: rtl/combo_tracker.sv
// Combo tracker: BCD current/max combo, full-combo and all-perfect flags from per-lane judgements.
// Latency: combo/flags 1 cycle after accum_now, max combo 2 cycles; optional milestone pulse via COMBO_MILESTONE_EN.
// Backpressure: none; a strobe every cycle is accepted, the max stage pipelines behind the combo stage.
module combo_tracker #(
   parameter int DIGITS    = 4,
   parameter int MILESTONE = 50
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  accum_now,
   input  logic [1:0]            result_up,
   input  logic [1:0]            result_down,
   output logic [4*DIGITS-1:0]   combo_bcd,
   output logic [4*DIGITS-1:0]   max_combo_bcd,
   output logic                  combo_valid,
   output logic                  full_combo,
   output logic                  all_perfect,
   output logic                  milestone
);

   localparam int W = 4 * DIGITS;
   localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

   // Judgement codes; 2'b11 is NO_NOTE and contributes nothing.
   localparam logic [1:0] PERFECT = 2'b00;
   localparam logic [1:0] GOOD    = 2'b01;
   localparam logic [1:0] MISS    = 2'b10;

   typedef enum logic [1:0] {IDLE, CLEAN, BROKEN} state_t;

   state_t         state_q, state_d;
   logic           perfect_q, perfect_d;
   logic [W-1:0]   combo_q, combo_d, combo_sum, max_q;
   logic           valid_q;
   logic           up_hit, dn_hit, miss, good;
   logic [1:0]     hits;
   logic [1:0]     carry;
   logic [4:0]     dsum, dsum_adj;

   // Per-strobe lane summary
   assign up_hit = (result_up == PERFECT) || (result_up == GOOD);
   assign dn_hit = (result_down == PERFECT) || (result_down == GOOD);
   assign hits   = {1'b0, up_hit} + {1'b0, dn_hit};
   assign miss   = (result_up == MISS) || (result_down == MISS);
   assign good   = (result_up == GOOD) || (result_down == GOOD);

   // BCD add of hits with per-digit carry; a carry out of the top digit saturates at all-9s
   always_comb begin
      combo_sum = '0;
      carry     = hits;
      dsum      = '0;
      dsum_adj  = '0;
      for (int d = 0; d < DIGITS; d++) begin
         dsum     = {1'b0, combo_q[4*d +: 4]} + {3'b000, carry};
         dsum_adj = dsum - 5'd10;
         if (dsum > 5'd9) begin
            combo_sum[4*d +: 4] = dsum_adj[3:0];
            carry               = 2'd1;
         end else begin
            combo_sum[4*d +: 4] = dsum[3:0];
            carry               = 2'd0;
         end
      end
      if (carry != 2'd0) begin
         combo_sum = ALL_NINES;
      end
   end

   // Next combo: a miss wins over any hit in the same strobe
   always_comb begin
      combo_d = combo_q;
      if (miss) begin
         combo_d = '0;
      end else if (hits != 2'd0) begin
         combo_d = combo_sum;
      end
   end

   // Combo register, update pulse, and max stage one cycle behind.
   // Unsigned compare of packed BCD equals a digit-wise MSD-first compare.
   always_ff @(posedge clk) begin
      if (rst) begin
         combo_q <= '0;
         valid_q <= 1'b0;
         max_q   <= '0;
      end else begin
         valid_q <= accum_now;
         if (accum_now) begin
            combo_q <= combo_d;
         end
         if (valid_q && (combo_q > max_q)) begin
            max_q <= combo_q;
         end
      end
   end

   // FSM state register with sticky perfect flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         perfect_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         perfect_q <= perfect_d;
      end
   end

   // FSM next state: BROKEN is terminal, all-NO_NOTE strobes hold state
   always_comb begin
      state_d   = state_q;
      perfect_d = perfect_q;
      if (accum_now) begin
         case (state_q)
            IDLE: begin
               if (miss) begin
                  state_d   = BROKEN;
                  perfect_d = 1'b0;
               end else if (hits != 2'd0) begin
                  state_d   = CLEAN;
                  perfect_d = !good;
               end
            end
            CLEAN: begin
               if (miss) begin
                  state_d   = BROKEN;
                  perfect_d = 1'b0;
               end else if (good) begin
                  perfect_d = 1'b0;
               end
            end
            default: begin
               state_d   = state_q;
               perfect_d = perfect_q;
            end
         endcase
      end
   end

   assign combo_bcd     = combo_q;
   assign max_combo_bcd = max_q;
   assign combo_valid   = valid_q;
   assign full_combo    = (state_q == CLEAN);
   assign all_perfect   = (state_q == CLEAN) && perfect_q;

`ifdef COMBO_MILESTONE_EN
   localparam int CW = $clog2(MILESTONE + 2);

   logic [CW-1:0] mcnt_q, mcnt_d;
   logic [CW:0]   msum;
   logic          mile_d, mile_q;

   // Mod-MILESTONE shadow of the combo; a +2 step over a boundary still fires
   always_comb begin
      mcnt_d = mcnt_q;
      mile_d = 1'b0;
      msum   = {1'b0, mcnt_q} + (CW+1)'(hits);
      if (miss) begin
         mcnt_d = '0;
      end else if ((hits != 2'd0) && (combo_q != ALL_NINES)) begin
         if (msum >= (CW+1)'(MILESTONE)) begin
            mcnt_d = CW'(msum - (CW+1)'(MILESTONE));
            mile_d = 1'b1;
         end else begin
            mcnt_d = msum[CW-1:0];
         end
      end
   end

   // Milestone counter and pulse, aligned with combo_valid
   always_ff @(posedge clk) begin
      if (rst) begin
         mcnt_q <= '0;
         mile_q <= 1'b0;
      end else begin
         mile_q <= accum_now && mile_d;
         if (accum_now) begin
            mcnt_q <= mcnt_d;
         end
      end
   end

   assign milestone = mile_q;
`else
   assign milestone = 1'b0;
`endif

endmodule

// File: tb/tb_combo_tracker.sv
// Testbench for combo_tracker: vector table for the main flow plus hand sequences
// for saturation, reset-over-strobe and (with COMBO_MILESTONE_EN) milestone pulses.
// Inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
module tb_combo_tracker;

   localparam logic [1:0] P = 2'b00;
   localparam logic [1:0] G = 2'b01;
   localparam logic [1:0] M = 2'b10;
   localparam logic [1:0] N = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic        accum_now;
   logic [1:0]  result_up, result_down;
   logic [15:0] combo_bcd, max_combo_bcd;
   logic        combo_valid, full_combo, all_perfect, milestone;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        acc;
      logic [1:0]  up;
      logic [1:0]  dn;
      logic [15:0] combo;
      logic [15:0] mx;
      logic        valid;
      logic        fc;
      logic        ap;
   } vec_t;

   vec_t vecs [18];

   always #5 clk = ~clk;

   combo_tracker #(.DIGITS(4), .MILESTONE(50)) dut (
      .clk           (clk),
      .rst           (rst),
      .accum_now     (accum_now),
      .result_up     (result_up),
      .result_down   (result_down),
      .combo_bcd     (combo_bcd),
      .max_combo_bcd (max_combo_bcd),
      .combo_valid   (combo_valid),
      .full_combo    (full_combo),
      .all_perfect   (all_perfect),
      .milestone     (milestone)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic acc, input logic [1:0] u, input logic [1:0] d);
      accum_now   = acc;
      result_up   = u;
      result_down = d;
      @(posedge clk);
      #1;
      accum_now = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " combo"}, combo_bcd, 16'h0000);
      check({tag, " max"}, max_combo_bcd, 16'h0000);
      check({tag, " valid"}, {15'b0, combo_valid}, 16'h0);
      check({tag, " fc"}, {15'b0, full_combo}, 16'h0);
      check({tag, " ap"}, {15'b0, all_perfect}, 16'h0);
      check({tag, " mile"}, {15'b0, milestone}, 16'h0);
   endtask

   initial begin
      // acc up dn -> combo max valid fc ap (max lags combo by one cycle)
      vecs[0]  = '{1'b1, P, N, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b1};
      vecs[1]  = '{1'b1, P, N, 16'h0002, 16'h0001, 1'b1, 1'b1, 1'b1};
      vecs[2]  = '{1'b1, P, N, 16'h0003, 16'h0002, 1'b1, 1'b1, 1'b1};
      vecs[3]  = '{1'b1, P, P, 16'h0005, 16'h0003, 1'b1, 1'b1, 1'b1};
      vecs[4]  = '{1'b0, P, P, 16'h0005, 16'h0005, 1'b0, 1'b1, 1'b1};
      vecs[5]  = '{1'b1, N, N, 16'h0005, 16'h0005, 1'b1, 1'b1, 1'b1};
      vecs[6]  = '{1'b1, P, P, 16'h0007, 16'h0005, 1'b1, 1'b1, 1'b1};
      vecs[7]  = '{1'b1, P, P, 16'h0009, 16'h0007, 1'b1, 1'b1, 1'b1};
      vecs[8]  = '{1'b1, P, P, 16'h0011, 16'h0009, 1'b1, 1'b1, 1'b1};
      vecs[9]  = '{1'b1, P, P, 16'h0013, 16'h0011, 1'b1, 1'b1, 1'b1};
      vecs[10] = '{1'b1, P, P, 16'h0015, 16'h0013, 1'b1, 1'b1, 1'b1};
      vecs[11] = '{1'b1, P, P, 16'h0017, 16'h0015, 1'b1, 1'b1, 1'b1};
      vecs[12] = '{1'b1, P, P, 16'h0019, 16'h0017, 1'b1, 1'b1, 1'b1};
      vecs[13] = '{1'b1, G, P, 16'h0021, 16'h0019, 1'b1, 1'b1, 1'b0};
      vecs[14] = '{1'b0, P, P, 16'h0021, 16'h0021, 1'b0, 1'b1, 1'b0};
      vecs[15] = '{1'b1, M, P, 16'h0000, 16'h0021, 1'b1, 1'b0, 1'b0};
      vecs[16] = '{1'b1, P, P, 16'h0002, 16'h0021, 1'b1, 1'b0, 1'b0};
      vecs[17] = '{1'b0, P, P, 16'h0002, 16'h0021, 1'b0, 1'b0, 1'b0};

      rst = 1'b1;
      accum_now = 1'b0;
      result_up = N;
      result_down = N;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;

      for (int i = 0; i < 18; i++) begin
         step(vecs[i].acc, vecs[i].up, vecs[i].dn);
         check($sformatf("v%0d combo", i), combo_bcd, vecs[i].combo);
         check($sformatf("v%0d max", i), max_combo_bcd, vecs[i].mx);
         check($sformatf("v%0d valid", i), {15'b0, combo_valid}, {15'b0, vecs[i].valid});
         check($sformatf("v%0d fc", i), {15'b0, full_combo}, {15'b0, vecs[i].fc});
         check($sformatf("v%0d ap", i), {15'b0, all_perfect}, {15'b0, vecs[i].ap});
         check($sformatf("v%0d mile", i), {15'b0, milestone}, 16'h0);
      end

      // Saturation: 4999 back-to-back double hits reach 9998
      rst = 1'b1;
      step(1'b0, N, N);
      rst = 1'b0;
      for (int i = 0; i < 4999; i++) step(1'b1, P, P);
      check("pre-sat combo", combo_bcd, 16'h9998);
      check("pre-sat max", max_combo_bcd, 16'h9996);
      check("pre-sat valid", {15'b0, combo_valid}, 16'h1);
      step(1'b1, P, G);
      check("sat combo", combo_bcd, 16'h9999);
      check("sat max", max_combo_bcd, 16'h9998);
      check("sat fc", {15'b0, full_combo}, 16'h1);
      check("sat ap", {15'b0, all_perfect}, 16'h0);
      step(1'b1, P, P);
      check("sat hold combo", combo_bcd, 16'h9999);
      check("sat hold valid", {15'b0, combo_valid}, 16'h1);
      check("sat hold max", max_combo_bcd, 16'h9999);

      // Reset dominates a same-cycle strobe
      rst = 1'b1;
      step(1'b1, P, P);
      rst = 1'b0;
      check_all_zero("rst+acc");

`ifdef COMBO_MILESTONE_EN
      begin
         int pulses;
         pulses = 0;
         for (int i = 0; i < 24; i++) begin
            step(1'b1, P, P);
            if (milestone) pulses++;
         end
         check("mile pre48 pulses", 16'(pulses), 16'h0);
         check("mile combo48", combo_bcd, 16'h0048);
         step(1'b1, P, P);
         check("mile at50 combo", combo_bcd, 16'h0050);
         check("mile at50", {15'b0, milestone}, 16'h1);
         step(1'b1, P, N);
         check("mile at51", {15'b0, milestone}, 16'h0);

         rst = 1'b1;
         step(1'b0, N, N);
         rst = 1'b0;
         for (int i = 0; i < 24; i++) step(1'b1, P, P);
         step(1'b1, P, N);
         check("mile combo49", combo_bcd, 16'h0049);
         step(1'b1, P, P);
         check("mile 49to51 combo", combo_bcd, 16'h0051);
         check("mile 49to51", {15'b0, milestone}, 16'h1);

         rst = 1'b1;
         step(1'b0, N, N);
         rst = 1'b0;
         for (int i = 0; i < 24; i++) step(1'b1, P, P);
         rst = 1'b1;
         step(1'b1, P, P);
         rst = 1'b0;
         check_all_zero("mile rst+acc");
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
